// File: rtl/rail_adc_scheduler_pkg.sv
// Shared types for the rail ADC scheduler: FSM state encoding and default sample width.
package roversPackage;

  localparam int RAIL_ADC_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    START,
    WAIT,
    DONE
  } rail_sched_state_t;

endpackage

// File: rtl/sweep_tick_gen.sv
// Free-running prescaler: tick is high for one cycle every DIV cycles (counter at DIV-1).
module sweep_tick_gen #(
  parameter int DIV = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick  = (cnt_q == CW'(DIV - 1));
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rail_adc_scheduler.sv
// Round-robin sweep of the enabled rail ADC channels through one shared reader,
// holding the latest sample, valid and fault flags per channel.
module rail_adc_scheduler
  import roversPackage::*;
#(
  parameter int SYSCLK_FREQ    = 100_000_000,
  parameter int NUM_ADCS       = 5,
  parameter int SWEEP_RATE_HZ  = 1000,
  parameter int DATA_W         = RAIL_ADC_DATA_W,
  parameter int TIMEOUT_CYCLES = 10_000,
  localparam int CHAN_W        = (NUM_ADCS > 1) ? $clog2(NUM_ADCS) : 1
) (
  input  logic                             sclk,
  input  logic                             rst,
  input  logic [NUM_ADCS-1:0]              chanEn,
  input  logic                             clrFlags,
  output logic                             convStart,
  output logic [CHAN_W-1:0]                convChan,
  input  logic                             convDone,
  input  logic [DATA_W-1:0]                convData,
  output logic [NUM_ADCS-1:0][DATA_W-1:0]  sample,
  output logic [NUM_ADCS-1:0]              sampleValid,
  output logic [NUM_ADCS-1:0]              timeoutFlag,
  output logic                             overrun,
  output logic                             sweepDone,
  output logic [15:0]                      sweepCount,
  output rail_sched_state_t                dbgState
);

  localparam int TICK_DIV = SYSCLK_FREQ / SWEEP_RATE_HZ;
  localparam int IDX_W    = $clog2(NUM_ADCS + 1);
  localparam int TO_W     = $clog2(TIMEOUT_CYCLES + 1);

  rail_sched_state_t                 state_q, state_d;
  logic [NUM_ADCS-1:0]               mask_q, mask_d;
  logic [IDX_W-1:0]                  idx_q, idx_d;
  logic [CHAN_W-1:0]                 chan_q, chan_d;
  logic [TO_W-1:0]                   to_cnt_q, to_cnt_d;
  logic [NUM_ADCS-1:0][DATA_W-1:0]   sample_q, sample_d;
  logic [NUM_ADCS-1:0]               valid_q, valid_d;
  logic [NUM_ADCS-1:0]               tflag_q, tflag_d;
  logic                              overrun_q, overrun_d;
  logic [15:0]                       sweep_count_q, sweep_count_d;
  logic                              tick;
  logic                              found;
  logic [CHAN_W-1:0]                 found_chan;

  sweep_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk  (sclk),
    .rst  (rst),
    .tick (tick)
  );

  // Lowest enabled channel at or above idx; scanning downward lets the lowest win.
  always_comb begin
    found      = 1'b0;
    found_chan = '0;
    for (int i = NUM_ADCS - 1; i >= 0; i--) begin
      if (mask_q[i] && (IDX_W'(i) >= idx_q)) begin
        found      = 1'b1;
        found_chan = CHAN_W'(i);
      end
    end
  end

  // Reader handshake: convStart pulses for one cycle in START with convChan already
  // stable; the reader answers with a one-cycle convDone carrying convData. A done
  // seen outside WAIT (late, or after a timeout) is dropped.
  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    idx_d         = idx_q;
    chan_d        = chan_q;
    to_cnt_d      = to_cnt_q;
    sample_d      = sample_q;
    valid_d       = valid_q;
    tflag_d       = tflag_q;
    overrun_d     = overrun_q;
    sweep_count_d = sweep_count_q;
    convStart     = 1'b0;
    sweepDone     = 1'b0;

    // Clears first so a set event later in this block wins in the same cycle.
    if (clrFlags) begin
      tflag_d   = '0;
      overrun_d = 1'b0;
    end
    if (tick && (state_q != IDLE)) overrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (tick) begin
          mask_d  = chanEn;
          idx_d   = '0;
          state_d = SELECT;
        end
      end
      SELECT: begin
        if (found) begin
          chan_d  = found_chan;
          idx_d   = IDX_W'(found_chan) + 1'b1;
          state_d = START;
        end else begin
          state_d = DONE;
        end
      end
      START: begin
        convStart = 1'b1;
        to_cnt_d  = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        if (convDone) begin
          sample_d[chan_q] = convData;
          valid_d[chan_q]  = 1'b1;
          state_d          = SELECT;
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          tflag_d[chan_q]  = 1'b1;
          valid_d[chan_q]  = 1'b0;
          state_d          = SELECT;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      DONE: begin
        sweepDone     = 1'b1;
        sweep_count_d = sweep_count_q + 16'd1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      mask_q        <= '0;
      idx_q         <= '0;
      chan_q        <= '0;
      to_cnt_q      <= '0;
      sample_q      <= '0;
      valid_q       <= '0;
      tflag_q       <= '0;
      overrun_q     <= 1'b0;
      sweep_count_q <= '0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      idx_q         <= idx_d;
      chan_q        <= chan_d;
      to_cnt_q      <= to_cnt_d;
      sample_q      <= sample_d;
      valid_q       <= valid_d;
      tflag_q       <= tflag_d;
      overrun_q     <= overrun_d;
      sweep_count_q <= sweep_count_d;
    end
  end

  assign convChan    = chan_q;
  assign sample      = sample_q;
  assign sampleValid = valid_q;
  assign timeoutFlag = tflag_q;
  assign overrun     = overrun_q;
  assign sweepCount  = sweep_count_q;
  assign dbgState    = state_q;

endmodule

// File: tb/tb_rail_adc_scheduler.sv
// Bench for rail_adc_scheduler: a cycle-level sweep model schedules expected starts,
// sweep ends and flag/sample updates; a monitor checks the DUT against it every cycle.
module tb_rail_adc_scheduler;
  import roversPackage::*;

  localparam int NUM_ADCS       = 5;
  localparam int DATA_W         = 16;
  localparam int SYSCLK_FREQ    = 400;
  localparam int SWEEP_RATE_HZ  = 1;
  localparam int TIMEOUT_CYCLES = 100;
  localparam int DIV            = SYSCLK_FREQ / SWEEP_RATE_HZ;
  localparam int CHAN_W         = 3;
  localparam int EV_GOOD = 0, EV_TMO = 1, EV_DONE = 2;

  typedef struct {
    int          cyc;
    int          ch;
    int          kind;
    logic [15:0] data;
  } ev_t;

  logic                            sclk = 1'b0;
  logic                            rst  = 1'b1;
  logic [NUM_ADCS-1:0]             chanEn = '0;
  logic                            clrFlags = 1'b0;
  logic                            convStart;
  logic [CHAN_W-1:0]               convChan;
  logic                            convDone = 1'b0;
  logic [DATA_W-1:0]               convData = '0;
  logic [NUM_ADCS-1:0][DATA_W-1:0] sample;
  logic [NUM_ADCS-1:0]             sampleValid;
  logic [NUM_ADCS-1:0]             timeoutFlag;
  logic                            overrun;
  logic                            sweepDone;
  logic [15:0]                     sweepCount;
  rail_sched_state_t               dbg_state;

  rail_adc_scheduler #(
    .SYSCLK_FREQ    (SYSCLK_FREQ),
    .NUM_ADCS       (NUM_ADCS),
    .SWEEP_RATE_HZ  (SWEEP_RATE_HZ),
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .sclk        (sclk),
    .rst         (rst),
    .chanEn      (chanEn),
    .clrFlags    (clrFlags),
    .convStart   (convStart),
    .convChan    (convChan),
    .convDone    (convDone),
    .convData    (convData),
    .sample      (sample),
    .sampleValid (sampleValid),
    .timeoutFlag (timeoutFlag),
    .overrun     (overrun),
    .sweepDone   (sweepDone),
    .sweepCount  (sweepCount),
    .dbgState    (dbg_state)
  );

  // ---------------- clock / reset / cycle index ----------------
  always #5 sclk = ~sclk;

  int cyc;
  always @(posedge sclk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [34:0] exp_start_q[$];   // {cycle, channel}
  logic [31:0] exp_done_q[$];    // cycle of sweepDone
  logic [47:0] rd_q[$];          // {latency, data} for the reader, 0 latency = never
  ev_t         ev_q[$];

  logic [NUM_ADCS-1:0][DATA_W-1:0] m_sample = '0;
  logic [NUM_ADCS-1:0]             m_valid  = '0;
  logic [NUM_ADCS-1:0]             m_tflag  = '0;
  logic                            m_ov     = 1'b0;
  logic [15:0]                     m_count  = '0;
  int busy_until = -1;
  int lat_cfg[NUM_ADCS];
  int gen = 0;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(string name, int got, int exp);
    checks++;
    failures++;
    $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  // A sweep started at tick T: first start at T+2, each channel costs L+2 (or
  // TIMEOUT+2 when the reader never answers in time), DONE at T+2+sum(costs).
  task automatic schedule_sweep(int k);
    int  t;
    ev_t e;
    t = k + 2;
    for (int ch = 0; ch < NUM_ADCS; ch++) begin
      if (chanEn[ch]) begin
        int          lat;
        logic [15:0] d;
        lat = lat_cfg[ch];
        d   = 16'($urandom);
        exp_start_q.push_back({32'(t), 3'(ch)});
        rd_q.push_back({32'(lat), d});
        e.ch   = ch;
        e.data = d;
        if (lat == 0 || lat > TIMEOUT_CYCLES) begin
          e.kind = EV_TMO;  e.cyc = t + TIMEOUT_CYCLES;  t += TIMEOUT_CYCLES + 2;
        end else begin
          e.kind = EV_GOOD; e.cyc = t + lat;             t += lat + 2;
        end
        ev_q.push_back(e);
      end
    end
    e.kind = EV_DONE; e.cyc = t; e.ch = 0; e.data = '0;
    ev_q.push_back(e);
    exp_done_q.push_back(32'(t));
    busy_until = t;
  endtask

  // Advances model outputs from "visible in cycle k" to "visible in cycle k+1".
  task automatic model_step();
    logic [NUM_ADCS-1:0] set_t;
    logic                set_ov;
    int                  k;
    ev_t                 e;
    set_t  = '0;
    set_ov = 1'b0;
    k      = cyc;
    if (k % DIV == DIV - 1) begin
      if (k <= busy_until) set_ov = 1'b1;
      else                 schedule_sweep(k);
    end
    while (ev_q.size() > 0 && ev_q[0].cyc == k) begin
      e = ev_q.pop_front();
      if (e.kind == EV_GOOD) begin
        m_sample[e.ch] = e.data;
        m_valid[e.ch]  = 1'b1;
      end else if (e.kind == EV_TMO) begin
        set_t[e.ch]    = 1'b1;
        m_valid[e.ch]  = 1'b0;
      end else begin
        m_count = m_count + 16'd1;
      end
    end
    if (clrFlags) begin
      m_tflag = '0;
      m_ov    = 1'b0;
    end
    m_tflag = m_tflag | set_t;
    m_ov    = m_ov | set_ov;
  endtask

  always @(negedge sclk) begin
    #1;
    if (!rst) model_step();
  end

  // ---------------- monitor ----------------
  always @(negedge sclk) begin
    if (!rst) begin
      if (convStart) begin
        if (exp_start_q.size() == 0) fail_now("conv_start_unexpected", int'(convChan), -1);
        else check("conv_start", {32'(cyc), convChan}, exp_start_q.pop_front());
      end else if (exp_start_q.size() > 0 && int'(exp_start_q[0][34:3]) < cyc) begin
        fail_now("conv_start_missing", cyc, int'(exp_start_q[0][34:3]));
        void'(exp_start_q.pop_front());
      end
      if (sweepDone) begin
        if (exp_done_q.size() == 0) fail_now("sweep_done_unexpected", cyc, -1);
        else check("sweep_done", 32'(cyc), exp_done_q.pop_front());
      end else if (exp_done_q.size() > 0 && int'(exp_done_q[0]) < cyc) begin
        fail_now("sweep_done_missing", cyc, int'(exp_done_q[0]));
        void'(exp_done_q.pop_front());
      end
      check("sample_valid", sampleValid, m_valid);
      check("timeout_flag", timeoutFlag, m_tflag);
      check("overrun", overrun, m_ov);
      check("sweep_count", sweepCount, m_count);
      check("sample", sample, m_sample);
    end
  end

  // ---------------- reader driver ----------------
  always begin
    @(negedge sclk);
    if (!rst && convStart && rd_q.size() > 0) begin
      logic [47:0] item;
      int          lat;
      int          my_gen;
      item   = rd_q.pop_front();
      lat    = int'(item[47:16]);
      my_gen = gen;
      if (lat != 0) begin
        repeat (lat) @(posedge sclk);
        #1;
        if (!rst && gen == my_gen) begin
          convDone = 1'b1;
          convData = item[15:0];
          @(posedge sclk);
          #1;
          convDone = 1'b0;
          convData = 16'($urandom);
        end
      end
    end
  end

  // ---------------- stimulus driver tasks ----------------
  task automatic wait_cyc(int c);
    int guard;
    guard = 0;
    while (cyc < c && guard < 20000) begin
      @(posedge sclk);
      #1;
      guard++;
    end
    if (cyc < c) fail_now("wait_cycle_budget", cyc, c);
  endtask

  task automatic pulse_clr(int c);
    wait_cyc(c);
    clrFlags = 1'b1;
    wait_cyc(c + 1);
    clrFlags = 1'b0;
  endtask

  task automatic set_lat_range(int lo, int hi);
    for (int i = 0; i < NUM_ADCS; i++) lat_cfg[i] = $urandom_range(hi, lo);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_conv_start"}, convStart, 1'b0);
    check({tag, "_conv_chan"}, convChan, '0);
    check({tag, "_sample"}, sample, '0);
    check({tag, "_sample_valid"}, sampleValid, '0);
    check({tag, "_timeout_flag"}, timeoutFlag, '0);
    check({tag, "_overrun"}, overrun, 1'b0);
    check({tag, "_sweep_done"}, sweepDone, 1'b0);
    check({tag, "_sweep_count"}, sweepCount, '0);
    check({tag, "_state"}, dbg_state, IDLE);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    set_lat_range(20, 20);
    repeat (3) @(posedge sclk);
    #1;
    check_reset_outputs("reset");
    #2;
    rst = 1'b0;

    // All channels, fixed latency 20: starts 22 cycles apart from T+2.
    wait_cyc(1);
    chanEn = 5'b11111;
    wait_cyc(600);

    // Sparse mask; mid-sweep enable change only affects the next sweep.
    chanEn = 5'b10100;
    set_lat_range(1, 30);
    wait_cyc(810);
    chanEn = 5'b00001;
    wait_cyc(1300);

    // Channel 3 silent, then answering one cycle too late; flags cleared in between.
    chanEn = 5'b11111;
    set_lat_range(1, 20);
    lat_cfg[3] = 0;
    wait_cyc(1700);
    lat_cfg[3] = TIMEOUT_CYCLES + 1;
    pulse_clr(1900);
    wait_cyc(2300);

    // Slow reader: sweeps outlast the tick period.
    set_lat_range(90, 90);
    pulse_clr(3000);
    pulse_clr(DIV * 9 - 1);
    wait_cyc(3700);

    // Empty sweeps through the sweep counter wrap.
    chanEn = '0;
    set_lat_range(10, 10);
    wait_cyc(4100);
    force dut.sweep_count_q = 16'hFFFE;
    m_count = 16'hFFFE;
    wait_cyc(4101);
    release dut.sweep_count_q;
    wait_cyc(5300);

    // Random sweeps with occasional silent channel and random flag clears.
    for (int i = 0; i < 3; i++) begin
      wait_cyc(5300 + DIV * i);
      chanEn = NUM_ADCS'($urandom);
      set_lat_range(1, 30);
      if ($urandom_range(3, 0) == 0) lat_cfg[$urandom_range(NUM_ADCS - 1, 0)] = 0;
      pulse_clr(5300 + DIV * i + $urandom_range(350, 50));
    end
    wait_cyc(6700);

    // Asynchronous reset while channel 1 is waiting on the reader.
    chanEn = 5'b11111;
    set_lat_range(20, 20);
    wait_cyc(6830);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    exp_start_q.delete();
    exp_done_q.delete();
    rd_q.delete();
    ev_q.delete();
    m_sample   = '0;
    m_valid    = '0;
    m_tflag    = '0;
    m_ov       = 1'b0;
    m_count    = '0;
    busy_until = -1;
    gen++;
    repeat (3) @(posedge sclk);
    #3;
    rst = 1'b0;
    wait_cyc(600);

    check("start_queue_drained", 32'(exp_start_q.size()), 32'd0);
    check("done_queue_drained", 32'(exp_done_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
